// File: rtl/poly_note_synth.sv
// Polyphonic square-wave synth: VOICES oscillators with attack/release envelopes, mixed and
// serialised to a stereo DAC. Define SYNTH_SAT_EN to clamp the mix instead of wrapping it.
module poly_note_synth #(
    parameter int unsigned VOICES       = 4,
    parameter int unsigned DIV_W        = 20,
    parameter int unsigned SAMPLE_W     = 16,
    parameter int unsigned AMP_SHIFT    = 5,
    parameter int unsigned ATTACK_STEP  = 32,
    parameter int unsigned RELEASE_STEP = 8,
    parameter int unsigned BCK_HALF     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [VOICES*DIV_W-1:0]      note_div,
    input  logic [VOICES-1:0]            voice_on,
    output logic                         audio_appsel,
    output logic                         audio_sysclk,
    output logic                         audio_bck,
    output logic                         audio_ws,
    output logic                         audio_data,
    output logic                         sample_strobe,
    output logic [$clog2(VOICES+1)-1:0]  active_voices
);

    localparam int unsigned SUB_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam int unsigned ACT_W = $clog2(VOICES + 1);
`ifdef SYNTH_SAT_EN
    localparam int unsigned SUM_W = SAMPLE_W + $clog2(VOICES);
`else
    // Wrapping is modular, so a SAMPLE_W-wide accumulator yields the same low bits.
    localparam int unsigned SUM_W = SAMPLE_W;
`endif

    logic [SUB_W-1:0]        sub_q, sub_d;
    logic [5:0]              hp_q, hp_d;
    logic                    frame_start;
    logic [VOICES-1:0]       phase_v, env_nz;
    logic signed [SUM_W-1:0] amp [VOICES];
    logic signed [SUM_W-1:0] sum;
    logic [SAMPLE_W-1:0]     mix, sample_q, word, word_sh;
    logic [ACT_W-1:0]        act_q, act_d;
    logic                    bck_q, ws_q, data_q, data_d, strobe_q, appsel_q;

    // hp counts bck half periods: bit 0 is bck, bits 4:1 the bit slot, bit 5 the channel.
    assign frame_start = (hp_q == 6'd0) && (sub_q == '0);

    always_comb begin
        sub_d = sub_q + SUB_W'(1);
        hp_d  = hp_q;
        if (sub_q == SUB_W'(BCK_HALF - 1)) begin
            sub_d = '0;
            hp_d  = hp_q + 6'd1;
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        logic [DIV_W-1:0] div, cnt_q, cnt_d;
        logic             phase_q, phase_d;
        logic [7:0]       env_q, env_d;
        logic [8:0]       env_up;

        assign div    = note_div[g*DIV_W +: DIV_W];
        assign env_up = {1'b0, env_q} + 9'(ATTACK_STEP);

        always_comb begin
            cnt_d   = cnt_q + DIV_W'(1);
            phase_d = phase_q;
            if (div == '0) begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end else if (cnt_q >= div - DIV_W'(1)) begin
                // >= also catches a divider shortened below the running count
                cnt_d   = '0;
                phase_d = ~phase_q;
            end
            env_d = env_q;
            if (frame_start) begin
                if (voice_on[g]) begin
                    env_d = env_up[8] ? 8'hFF : env_up[7:0];
                end else begin
                    env_d = (env_q >= 8'(RELEASE_STEP)) ? env_q - 8'(RELEASE_STEP) : 8'h00;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
                env_q   <= '0;
            end else begin
                cnt_q   <= cnt_d;
                phase_q <= phase_d;
                env_q   <= env_d;
            end
        end

        assign amp[g]     = SUM_W'(env_q) << AMP_SHIFT;
        assign phase_v[g] = phase_q;
        assign env_nz[g]  = |env_d;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            sum = phase_v[i] ? sum + amp[i] : sum - amp[i];
        end
    end

`ifdef SYNTH_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (SAMPLE_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (SAMPLE_W - 1)));

    always_comb begin
        if (sum > SAT_MAX) begin
            mix = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            mix = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            mix = sum[SAMPLE_W-1:0];
        end
    end
`else
    assign mix = sum;
`endif

    always_comb begin
        act_d = '0;
        for (int i = 0; i < VOICES; i++) begin
            act_d = act_d + ACT_W'(env_nz[i]);
        end
    end

    // The frame-start slot sends the fresh mix so the MSB leaves with the strobe.
    assign word    = frame_start ? mix : sample_q;
    assign word_sh = word << hp_q[4:1];
    assign data_d  = word_sh[SAMPLE_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q    <= '0;
            hp_q     <= '0;
            sample_q <= '0;
            act_q    <= '0;
            bck_q    <= 1'b0;
            ws_q     <= 1'b0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
            appsel_q <= 1'b0;
        end else begin
            sub_q    <= sub_d;
            hp_q     <= hp_d;
            bck_q    <= hp_q[0];
            ws_q     <= hp_q[5];
            data_q   <= data_d;
            strobe_q <= frame_start;
            appsel_q <= 1'b1;
            if (frame_start) begin
                sample_q <= mix;
                act_q    <= act_d;
            end
        end
    end

    assign audio_appsel  = appsel_q;
    assign audio_sysclk  = clk;
    assign audio_bck     = bck_q;
    assign audio_ws      = ws_q;
    assign audio_data    = data_q;
    assign sample_strobe = strobe_q;
    assign active_voices = act_q;

endmodule
